usbf_sof_tracker: RTL and testbench

- Parametrised successor to the protocol layer's frame/SOF timekeeping: tracks frame number, micro-frame count and time since the last SOF.
- Adds an SOF-loss watchdog that synthesises missing SOFs, counts consecutive misses and flags loss of sync.
- Sits between the packet decoder (qualified SOF strobe plus frame number) and the register file (frame/time status) and protocol engine.

---
 rtl/usbf_sof_pkg.sv | 11 +
 rtl/usbf_hms_gen.sv | 40 ++++
 rtl/usbf_sof_tracker.sv | 128 ++++++++++++
 tb/tb_usbf_sof_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usbf_sof_pkg.sv
// Shared defaults for the SOF/frame timekeeping block.
package usbf_sof_pkg;

  localparam int HMS_DEL_DEF  = 22;
  localparam int FS_MISS_DEF  = 2010;
  localparam int HS_MISS_DEF  = 260;
  localparam int MFM_PER_FRM  = 8;
  localparam int MAX_MISS_DEF = 3;
  localparam int MISS_W       = 2;

endpackage

// File: rtl/usbf_hms_gen.sv
// Half-microsecond tick divider: one tick per HMS_DEL+1 clocks, re-phased by clr, frozen by hold.
module usbf_hms_gen
  import usbf_sof_pkg::*;
#(
  parameter int HMS_DEL = HMS_DEL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic hms_tick
);

  localparam int CNT_W = (HMS_DEL > 0) ? $clog2(HMS_DEL + 1) : 1;

  logic [CNT_W-1:0] hms_cnt_reg, hms_cnt_next;
  logic             at_del_reg;

  always_comb begin
    hms_cnt_next = hms_cnt_reg;
    if (clr)
      hms_cnt_next = '0;
    else if (!hold)
      hms_cnt_next = (hms_cnt_reg == CNT_W'(HMS_DEL)) ? '0 : hms_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hms_cnt_reg <= '0;
      at_del_reg  <= 1'b0;
    end else begin
      hms_cnt_reg <= hms_cnt_next;
      at_del_reg  <= (hms_cnt_next == CNT_W'(HMS_DEL));
    end
  end

  // Counter parks on HMS_DEL during hold, so the masked tick is emitted once hold drops.
  assign hms_tick = at_del_reg && !hold;

endmodule

// File: rtl/usbf_sof_tracker.sv
// Frame number, micro-frame and SOF-time tracking; the SOF-loss watchdog
// (synthetic SOFs, miss_cnt, sync_lost) is built only with USBF_SOF_WDOG_EN.
module usbf_sof_tracker
  import usbf_sof_pkg::*;
#(
  parameter int FRM_W    = 11,
  parameter int MFM_W    = 4,
  parameter int TIME_W   = 12,
  parameter int HMS_DEL  = HMS_DEL_DEF,
  parameter int FS_MISS  = FS_MISS_DEF,
  parameter int HS_MISS  = HS_MISS_DEF,
  parameter int MAX_MISS = MAX_MISS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_hs,
  input  logic              usb_reset,
  input  logic              usb_suspend,
  input  logic              sof_valid,
  input  logic [FRM_W-1:0]  frame_no,
  output logic [FRM_W-1:0]  frame_no_r,
  output logic [MFM_W-1:0]  mfm_cnt,
  output logic [TIME_W-1:0] sof_time,
  output logic              hms_tick,
  output logic              sof_tick,
  output logic              sof_missed,
  output logic [MISS_W-1:0] miss_cnt,
  output logic              sync_lost,
  output logic              synced
);

  localparam logic [MFM_W-1:0] MFM_LAST = MFM_W'(MFM_PER_FRM - 1);

  logic [FRM_W-1:0]  frame_reg;
  logic [MFM_W-1:0]  mfm_reg, mfm_inc;
  logic [TIME_W-1:0] time_reg;
  logic              sof_tick_reg, synced_reg;
  logic [TIME_W:0]   miss_thr;
  logic              thr_hit, wdog_fire;

  usbf_hms_gen #(.HMS_DEL(HMS_DEL)) u_hms_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (usb_reset | sof_valid),
    .hold     (usb_suspend),
    .hms_tick (hms_tick)
  );

  assign mfm_inc  = (mfm_reg == '1) ? mfm_reg : mfm_reg + 1'b1;
  assign miss_thr = mode_hs ? (TIME_W+1)'(HS_MISS) : (TIME_W+1)'(FS_MISS);
  // Widened compare so a saturated sof_time can never alias a threshold.
  assign thr_hit  = hms_tick && (({1'b0, time_reg} + 1'b1) == miss_thr);

  always_ff @(posedge clk) begin
    if (rst || usb_reset) begin
      frame_reg    <= '0;
      mfm_reg      <= '0;
      time_reg     <= '0;
      sof_tick_reg <= 1'b0;
      synced_reg   <= 1'b0;
    end else if (sof_valid) begin
      frame_reg    <= frame_no;
      mfm_reg      <= (frame_no == frame_reg && synced_reg) ? mfm_inc : '0;
      time_reg     <= '0;
      sof_tick_reg <= 1'b1;
      synced_reg   <= 1'b1;
    end else if (wdog_fire) begin
      time_reg     <= '0;
      sof_tick_reg <= 1'b1;
      if (mode_hs && mfm_reg != MFM_LAST) begin
        mfm_reg <= mfm_inc;
      end else begin
        mfm_reg   <= '0;
        frame_reg <= frame_reg + 1'b1;
      end
    end else begin
      sof_tick_reg <= 1'b0;
      if (hms_tick && time_reg != '1)
        time_reg <= time_reg + 1'b1;
    end
  end

`ifdef USBF_SOF_WDOG_EN
  logic [MISS_W-1:0] miss_reg, miss_inc;
  logic              lost_reg, missed_reg;

  assign miss_inc  = (miss_reg == '1) ? miss_reg : miss_reg + 1'b1;
  assign wdog_fire = synced_reg && !lost_reg && !usb_suspend && thr_hit;

  always_ff @(posedge clk) begin
    if (rst || usb_reset) begin
      miss_reg   <= '0;
      lost_reg   <= 1'b0;
      missed_reg <= 1'b0;
    end else if (sof_valid) begin
      miss_reg   <= '0;
      lost_reg   <= 1'b0;
      missed_reg <= 1'b0;
    end else if (wdog_fire) begin
      miss_reg   <= miss_inc;
      missed_reg <= 1'b1;
      if (int'(miss_inc) == MAX_MISS)
        lost_reg <= 1'b1;
    end else begin
      missed_reg <= 1'b0;
    end
  end

  assign sof_missed = missed_reg;
  assign miss_cnt   = miss_reg;
  assign sync_lost  = lost_reg;
`else
  logic wdog_unused;

  assign wdog_unused = thr_hit ^ (MAX_MISS > 0);
  assign wdog_fire   = 1'b0;
  assign sof_missed  = 1'b0;
  assign miss_cnt    = '0;
  assign sync_lost   = 1'b0;
`endif

  assign frame_no_r = frame_reg;
  assign mfm_cnt    = mfm_reg;
  assign sof_time   = time_reg;
  assign sof_tick   = sof_tick_reg;
  assign synced     = synced_reg;

endmodule

// File: tb/tb_usbf_sof_tracker.sv
// Scoreboard bench for usbf_sof_tracker: directed scenarios plus random traffic vs. a cycle-level reference model.
module tb_usbf_sof_tracker;

  localparam int FRM_W    = 11;
  localparam int MFM_W    = 4;
  localparam int TIME_W   = 12;
  localparam int HMS_DEL  = 3;
  localparam int FS_MISS  = 10;
  localparam int HS_MISS  = 4;
  localparam int MAX_MISS = 3;
`ifdef USBF_SOF_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, mode_hs, usb_reset, usb_suspend, sof_valid;
  logic [FRM_W-1:0]  frame_no;
  logic [FRM_W-1:0]  frame_no_r;
  logic [MFM_W-1:0]  mfm_cnt;
  logic [TIME_W-1:0] sof_time;
  logic              hms_tick, sof_tick, sof_missed, sync_lost, synced;
  logic [1:0]        miss_cnt;

  always #5 clk = ~clk;

  usbf_sof_tracker #(
    .FRM_W(FRM_W), .MFM_W(MFM_W), .TIME_W(TIME_W), .HMS_DEL(HMS_DEL),
    .FS_MISS(FS_MISS), .HS_MISS(HS_MISS), .MAX_MISS(MAX_MISS)
  ) dut (
    .clk(clk), .rst(rst), .mode_hs(mode_hs), .usb_reset(usb_reset),
    .usb_suspend(usb_suspend), .sof_valid(sof_valid), .frame_no(frame_no),
    .frame_no_r(frame_no_r), .mfm_cnt(mfm_cnt), .sof_time(sof_time),
    .hms_tick(hms_tick), .sof_tick(sof_tick), .sof_missed(sof_missed),
    .miss_cnt(miss_cnt), .sync_lost(sync_lost), .synced(synced)
  );

  typedef struct packed {
    logic [10:0] frame;
    logic [3:0]  mfm;
    logic [11:0] stime;
    logic        hms;
    logic        sof;
    logic        missed;
    logic [1:0]  miss;
    logic        lost;
    logic        sync;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state, in plain integers.
  int m_frame, m_mfm, m_time, m_phase, m_miss;
  bit m_sof, m_missed, m_lost, m_synced;
  bit model_ok = 1'b0;

  function automatic obs_t model_obs();
    obs_t o;
    o.frame  = 11'(m_frame);
    o.mfm    = 4'(m_mfm);
    o.stime  = 12'(m_time);
    o.hms    = (m_phase == HMS_DEL) && !usb_suspend;
    o.sof    = m_sof;
    o.missed = m_missed;
    o.miss   = 2'(m_miss);
    o.lost   = m_lost;
    o.sync   = m_synced;
    return o;
  endfunction

  task automatic model_advance();
    bit tick;
    int thr;
    tick = (m_phase == HMS_DEL) && !usb_suspend;
    thr  = mode_hs ? HS_MISS : FS_MISS;
    if (rst || usb_reset) begin
      m_frame = 0; m_mfm = 0; m_time = 0; m_phase = 0; m_miss = 0;
      m_sof = 0; m_missed = 0; m_lost = 0; m_synced = 0;
    end else if (sof_valid) begin
      m_mfm    = (int'(frame_no) == m_frame && m_synced) ? ((m_mfm < 15) ? m_mfm + 1 : 15) : 0;
      m_frame  = int'(frame_no);
      m_time   = 0; m_phase = 0; m_miss = 0;
      m_sof    = 1; m_missed = 0; m_lost = 0; m_synced = 1;
    end else begin
      m_sof = 0; m_missed = 0;
      if (!usb_suspend) m_phase = (m_phase == HMS_DEL) ? 0 : m_phase + 1;
      if (tick) begin
        if (WDOG && m_synced && !m_lost && m_time + 1 == thr) begin
          m_time   = 0; m_sof = 1; m_missed = 1;
          m_miss   = (m_miss < 3) ? m_miss + 1 : 3;
          if (m_miss == MAX_MISS) m_lost = 1;
          if (mode_hs && m_mfm != 7) begin
            m_mfm = (m_mfm < 15) ? m_mfm + 1 : 15;
          end else begin
            m_mfm   = 0;
            m_frame = (m_frame + 1) % 2048;
          end
        end else if (m_time < 4095) begin
          m_time = m_time + 1;
        end
      end
    end
    model_ok = 1'b1;
  endtask

  // Inputs for the current cycle are already applied when this is called.
  task automatic clk_cycle();
    if (model_ok) exp_q.push_back(model_obs());
    model_advance();
    @(posedge clk);
    #1;
    sof_valid = 1'b0;
    usb_reset = 1'b0;
    frame_no  = 11'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) clk_cycle();
  endtask

  task automatic sof(input logic [10:0] f);
    sof_valid = 1'b1;
    frame_no  = f;
    clk_cycle();
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {frame_no_r, mfm_cnt, sof_time, hms_tick, sof_tick, sof_missed, miss_cnt, sync_lost, synced};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cyc%0d outputs got frame=%h mfm=%0d time=%0d hms=%b sof=%b missed=%b miss=%0d lost=%b synced=%b want frame=%h mfm=%0d time=%0d hms=%b sof=%b missed=%b miss=%0d lost=%b synced=%b",
                   cyc, a.frame, a.mfm, a.stime, a.hms, a.sof, a.missed, a.miss, a.lost, a.sync,
                   e.frame, e.mfm, e.stime, e.hms, e.sof, e.missed, e.miss, e.lost, e.sync);
        end
        if (a.sof === 1'b1)
          $display("cyc%0d sof frame=%h mfm=%0d missed=%b miss_cnt=%0d sync_lost=%b",
                   cyc, a.frame, a.mfm, a.missed, a.miss, a.lost);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; usb_reset = 1'b0; usb_suspend = 1'b0; mode_hs = 1'b0;
    sof_valid = 1'b0; frame_no = '0;
    idle(3);
    rst = 1'b0;
    idle(3);

    // Tick alignment and sof_time counting after a first SOF.
    sof(11'h123);
    idle(25);

    // HS micro-frame stepping, then a new frame number.
    mode_hs = 1'b1;
    repeat (8) begin sof(11'h010); idle($urandom_range(1, 6)); end
    sof(11'h011);
    idle(4);

    // Frame wrap via synthetic SOF and loss of sync, then recovery.
    repeat (8) begin sof(11'h7FF); idle($urandom_range(1, 6)); end
    idle(80);
    sof(11'h200);
    idle(5);

    // Real SOF landing on the exact threshold tick.
    for (int i = 0; i < 200; i++) begin
      if (m_phase == HMS_DEL && m_time + 1 == (mode_hs ? HS_MISS : FS_MISS)) break;
      clk_cycle();
    end
    sof(11'h055);
    idle(10);

    // Suspend freeze, then bus reset.
    usb_suspend = 1'b1;
    idle(100);
    usb_suspend = 1'b0;
    idle(7);
    usb_reset = 1'b1;
    clk_cycle();
    idle(10);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 25) begin
        sof_valid = 1'b1;
        frame_no  = ($urandom_range(0, 1) == 1) ? 11'(m_frame) : 11'($urandom);
      end else if (r < 28) begin
        mode_hs = ~mode_hs;
      end else if (r < 30) begin
        usb_reset = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) usb_suspend = ~usb_suspend;
      clk_cycle();
    end
    usb_suspend = 1'b0;

    // Long silence: sof_time must saturate, never wrap.
    mode_hs = 1'b0;
    sof(11'h3AB);
    idle(4096 * 4 + 50);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
